// File: rtl/core_output_collector_if.sv
// rtl/core_output_collector_if.sv - result-word output stream between the collector and the writeback path
interface core_output_collector_if #(
    parameter int DW = 64
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/core_output_collector.sv
// rtl/core_output_collector.sv - captures systolic core result words into a FWFT FIFO and streams them out in frames
module core_output_collector #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_BLOCKS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          soft_clr,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   in_data,
    input  logic                          in_finish,
    core_output_collector_if.master       m,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int DW = WIDTH * CHUNK_SIZE;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (OUT_BLOCKS > 1) ? $clog2(OUT_BLOCKS) : 1;

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [BW-1:0] beat_q;
    logic          overflow_q, frame_done_q;
    logic          valid, pop, full, capture, push, drop, last_beat;

    assign valid     = (level_q != '0);
    assign last_beat = (beat_q == BW'(OUT_BLOCKS - 1));
    assign pop       = valid & m.m_ready;
    assign capture   = en & in_finish;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts that push.
    assign full      = (level_q == LW'(FIFO_DEPTH)) & ~pop;
    assign push      = capture & ~full & ~soft_clr;
    assign drop      = capture & full & ~soft_clr;

    // Gated so the outputs read zero while empty, including straight out of reset.
    assign m.m_valid = valid;
    assign m.m_data  = valid ? mem_q[rd_ptr_q] : '0;
    assign m.m_last  = valid & last_beat;

    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign level      = level_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            beat_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (soft_clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            beat_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                beat_q   <= last_beat ? '0 : beat_q + BW'(1);
            end
            level_q      <= level_d;
            frame_done_q <= pop & last_beat;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_core_output_collector.sv
// tb/tb_core_output_collector.sv - self-checking bench for core_output_collector against a queue-based model
module tb_core_output_collector;
    localparam int W  = 16;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int OB = 4;
    localparam int DW = W * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          soft_clr = 1'b0;
    logic          in_finish = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          frame_done;
    logic          overflow;
    logic [3:0]    level;

    int compared = 0;
    int mismatched = 0;

    core_output_collector_if #(.DW(DW)) mif ();

    core_output_collector #(
        .WIDTH(W), .CHUNK_SIZE(C), .FIFO_DEPTH(D), .OUT_BLOCKS(OB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .soft_clr(soft_clr),
        .in_data(in_data), .in_finish(in_finish), .m(mif),
        .frame_done(frame_done), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain word queue, a beat index and two flags.
    logic [DW-1:0] mq[$];
    int  mbeat = 0;
    bit  mov = 1'b0;
    bit  mfd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mbeat = 0;
            mov   = 1'b0;
            mfd   = 1'b0;
        end else if (soft_clr) begin
            mq.delete();
            mbeat = 0;
            mov   = 1'b0;
            mfd   = 1'b0;
        end else begin
            int sz;
            bit p;
            sz  = mq.size();
            p   = (sz > 0) && mif.m_ready;
            mfd = p && (mbeat == OB - 1);
            if (p) begin
                void'(mq.pop_front());
                mbeat = (mbeat + 1) % OB;
            end
            if (en && in_finish) begin
                if (sz < D || p) mq.push_back(in_data);
                else mov = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        cmp("m_valid", mif.m_valid, mq.size() > 0);
        cmp("m_data", mif.m_data, (mq.size() > 0) ? mq[0] : 64'd0);
        cmp("m_last", mif.m_last, (mq.size() > 0) && (mbeat == OB - 1));
        cmp("level", level, mq.size());
        cmp("overflow", overflow, mov);
        cmp("frame_done", frame_done, mfd);
    end

    bit       mon_on = 1'b0;
    int       pop_idx = 0;
    int       fd_cnt = 0;
    logic [7:0] lastmask = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (mif.m_valid && mif.m_ready) begin
                if (mif.m_last && pop_idx < 8) lastmask[pop_idx] = 1'b1;
                pop_idx++;
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [DW-1:0] d);
        in_finish = 1'b1;
        in_data   = d;
        tick();
        in_finish = 1'b0;
    endtask

    task automatic clr();
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        mif.m_ready = 1'b0;
        repeat (2) tick();
        cmp("reset_level", level, 0);
        cmp("reset_valid", mif.m_valid, 0);
        cmp("reset_overflow", overflow, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick();

        // Single capture
        mif.m_ready = 1'b1;
        cap(64'h0001_0002_0003_0004);
        #3;
        cmp("single_valid", mif.m_valid, 1);
        cmp("single_data", mif.m_data, 64'h0001_0002_0003_0004);
        tick();
        cmp("single_level", level, 0);

        // Fill, full push+pop, overflow, stalled drain
        clr();
        mif.m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) cap(DW'(i));
        cmp("fill_level", level, 8);
        mif.m_ready = 1'b1;
        cap(DW'(9));
        mif.m_ready = 1'b0;
        cmp("fullpp_level", level, 8);
        cmp("fullpp_overflow", overflow, 0);
        cap(DW'(10));
        cmp("drop_overflow", overflow, 1);
        cmp("drop_level", level, 8);
        repeat (3) tick();
        cmp("stall_head", mif.m_data, 2);
        mif.m_ready = 1'b1;
        repeat (9) tick();
        cmp("drain_level", level, 0);
        cmp("drain_overflow_sticky", overflow, 1);

        // Framing: OUT_BLOCKS=4, 8 words
        clr();
        mon_on = 1'b1;
        for (int i = 0; i < 8; i++) cap(DW'(100 + i));
        repeat (3) tick();
        mon_on = 1'b0;
        cmp("frame_done_count", fd_cnt, 2);
        cmp("last_beat_mask", lastmask, 8'h88);

        // soft_clr with simultaneous capture
        clr();
        mif.m_ready = 1'b0;
        for (int i = 0; i < 9; i++) cap(DW'(200 + i));
        mif.m_ready = 1'b1;
        repeat (3) tick();
        mif.m_ready = 1'b0;
        cmp("pre_clr_level", level, 5);
        cmp("pre_clr_overflow", overflow, 1);
        soft_clr  = 1'b1;
        in_finish = 1'b1;
        in_data   = DW'(299);
        tick();
        soft_clr  = 1'b0;
        in_finish = 1'b0;
        cmp("clr_level", level, 0);
        cmp("clr_valid", mif.m_valid, 0);
        cmp("clr_overflow", overflow, 0);
        cap(DW'(300));
        cmp("post_clr_valid", mif.m_valid, 1);
        cmp("post_clr_last", mif.m_last, 0);

        // Async reset mid-stall
        clr();
        for (int i = 0; i < 3; i++) cap(DW'(400 + i));
        cmp("prereset_level", level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("areset_data", mif.m_data, 0);
        cmp("areset_valid", mif.m_valid, 0);
        cmp("areset_last", mif.m_last, 0);
        cmp("areset_fd", frame_done, 0);
        cmp("areset_overflow", overflow, 0);
        cmp("areset_level", level, 0);
        tick();
        rst_n = 1'b1;
        tick();
        cmp("post_reset_level", level, 0);
        mif.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) cap(DW'(500 + i));
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/core_output_collector.md
Name: core_output_collector

Overview:
- Downstream stage of the systolic MAC core. Captures each WIDTH*CHUNK_SIZE result word when the core pulses systolic_finish. Buffers the words in a small first-word-fall-through FIFO.
- Streams buffered words out over a valid/ready interface, with beat counting and frame-boundary marking.
- Decouples the fixed-rate core from backpressure in the writeback path.

Parameters:
- WIDTH, 16, element bit width (matches core)
- CHUNK_SIZE, 4, elements per result word (matches core)
- FIFO_DEPTH, 8, result-word entries; power of two, ≥2
- OUT_BLOCKS, 16, result words per output frame (one output matrix); ≥1

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  capture enable, same signal that drives the core
- soft_clr  input  1  synchronous flush of FIFO, beat counter and overflow flag
- in_data  input  WIDTH*CHUNK_SIZE  result word from core out
- in_finish  input  1  core systolic_finish; a capture qualifier
- m_data  output  WIDTH*CHUNK_SIZE  head-of-FIFO word
- m_valid  output  1  m_data valid
- m_ready  input  1  downstream accepts the beat
- m_last  output  1  current beat is word OUT_BLOCKS-1 of the frame
- frame_done  output  1  one-cycle pulse after the last beat of a frame handshakes
- overflow  output  1  sticky flag: a capture was dropped
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0. This covers m_data, m_valid, m_last, frame_done, overflow and level. Pointers, beat counter and occupancy are cleared. Storage contents are don't-care.
- Push: push = en & in_finish & ~full. The word is written on that rising edge. Each cycle with in_finish high is a separate push; there is no edge detection.
- Pop: pop = m_valid & m_ready.
- FWFT behaviour: a word pushed at edge N into an empty FIFO gives m_valid=1 and m_data = that word from after edge N. Latency is 1 cycle.
- m_data and m_valid are held stable while m_valid=1 and m_ready=0.
- Full with pop in the same cycle: a push is accepted that cycle, and level is unchanged. Full is evaluated as "level==FIFO_DEPTH and no pop".
- Empty with push in the same cycle: the push is taken and no pop occurs, since m_valid was 0.
- Dropped capture: en & in_finish while full and no pop. The word is discarded and overflow is set the next cycle. overflow stays set until soft_clr or reset.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo FIFO_DEPTH.
- Beat counter: range 0..OUT_BLOCKS-1, incremented on each pop, wraps to 0 after OUT_BLOCKS-1.
- m_last = m_valid & (beat_cnt == OUT_BLOCKS-1), combinational from registered state. When OUT_BLOCKS=1, every beat is last.
- frame_done is registered and high for exactly the one cycle after a pop with m_last=1.
- en low: no captures. Output streaming continues regardless of en.
- soft_clr (synchronous, highest priority): on that edge, FIFO is emptied, beat counter=0, overflow=0, frame_done=0. A push in the same cycle is discarded and does not set overflow. m_valid=0 from the next cycle.
- Reset mid-frame: partial frame is lost, and the beat count restarts at 0.

Test Plan:
- Single capture: with m_ready=1, in_data=0x0001_0002_0003_0004 and in_finish=1 for 1 cycle -> m_valid=1 the next cycle with that data; popped; level returns 0.
- Backpressure fill: m_ready=0, 10 captures of values 1..10 with FIFO_DEPTH=8 -> level=8, overflow=1 after the 9th. Then m_ready=1 -> beats 1..8 in order, m_data held stable throughout the stall.
- Full with simultaneous push/pop: level=8, in_finish=1 and m_ready=1 in the same cycle -> push accepted, level stays 8, overflow stays 0.
- Framing: OUT_BLOCKS=4, 8 words streamed -> m_last on beats 4 and 8; frame_done pulses 1 cycle after each of those beats, 2 pulses total.
- soft_clr: level=5, overflow=1, soft_clr asserted together with in_finish -> next cycle level=0, m_valid=0, overflow=0; the next frame's first beat is not last.
- Async reset: rst_n dropped mid-beat, with m_ready=0 and level=3 -> all outputs 0 immediately, before the next clk edge; after release the FIFO is empty and the beat count is 0.
